// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: redirects, hazard stalls, I-cache miss waits and HLT.
// Define PC_FETCH_PERF_EN to add the stall_cycles/flush_count performance counters.
module pc_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'h0002
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        hazard_stall,
  input  logic        halt_decoded,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus_2,
  output logic        ifid_wen,
  output logic        ifid_flush,
  output logic        halted
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  localparam logic [1:0] ST_FETCH    = 2'd0;
  localparam logic [1:0] ST_WAIT_MEM = 2'd1;
  localparam logic [1:0] ST_HALTED   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pend_target_q, pend_target_d;
  logic        pend_valid_q, pend_valid_d;
  logic        halt_pend_q, halt_pend_d;
  logic        halted_q;
  logic        wen, flush, redirect;

  assign pc_out     = pc_q;
  assign pc_plus_2  = pc_q + PC_STEP;
  assign halted     = halted_q;
  assign imem_req   = rst_n & (state_q != ST_HALTED);
  assign ifid_wen   = rst_n & wen;
  assign ifid_flush = rst_n & flush;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    pend_valid_d  = pend_valid_q;
    halt_pend_d   = halt_pend_q;
    wen           = 1'b0;
    flush         = 1'b0;
    redirect      = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (branch_taken) begin
          pc_d     = branch_target;
          flush    = 1'b1;
          redirect = 1'b1;
        end else if (halt_decoded) begin
          flush   = 1'b1;
          state_d = ST_HALTED;
        end else if (hazard_stall) begin
          // IF/ID holds its contents: neither written nor flushed.
        end else if (!imem_ready) begin
          flush   = 1'b1;
          state_d = ST_WAIT_MEM;
        end else begin
          pc_d = pc_plus_2;
          wen  = 1'b1;
        end
      end
      ST_WAIT_MEM: begin
        flush = 1'b1;
        if (imem_ready) begin
          state_d      = ST_FETCH;
          pend_valid_d = 1'b0;
          halt_pend_d  = 1'b0;
          if (branch_taken) begin
            pc_d     = branch_target;
            redirect = 1'b1;
          end else if (pend_valid_q) begin
            pc_d     = pend_target_q;
            redirect = 1'b1;
          end else if (halt_pend_q) begin
            state_d = ST_HALTED;
          end
        end else if (branch_taken) begin
          // The miss is never abandoned; the newest redirect waits for imem_ready.
          pend_target_d = branch_target;
          pend_valid_d  = 1'b1;
          halt_pend_d   = 1'b0;
        end else if (halt_decoded && !pend_valid_q) begin
          halt_pend_d = 1'b1;
        end
      end
      ST_HALTED: begin
        flush = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      pend_target_q <= 16'h0000;
      pend_valid_q  <= 1'b0;
      halt_pend_q   <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      pend_valid_q  <= pend_valid_d;
      halt_pend_q   <= halt_pend_d;
      halted_q      <= (state_d == ST_HALTED);
    end
  end

`ifdef PC_FETCH_PERF_EN
  logic [15:0] stall_q, flush_cnt_q;
  logic        stall_evt;

  assign stall_evt    = (state_q == ST_WAIT_MEM) || ((state_q == ST_FETCH) && hazard_stall);
  assign stall_cycles = stall_q;
  assign flush_count  = flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q     <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      if (stall_evt && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (redirect && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end
`else
  logic unused_redirect;
  assign unused_redirect = redirect;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: behavioural fetch model plus literal checkpoints.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        hazard_stall;
  logic        halt_decoded;
  logic        imem_ready;
  logic        imem_req;
  logic [15:0] pc_out;
  logic [15:0] pc_plus_2;
  logic        ifid_wen;
  logic        ifid_flush;
  logic        halted;

  pc_fetch_ctrl #(
    .RESET_PC(16'h0000),
    .PC_STEP (16'h0002)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .hazard_stall (hazard_stall),
    .halt_decoded (halt_decoded),
    .imem_ready   (imem_ready),
    .imem_req     (imem_req),
    .pc_out       (pc_out),
    .pc_plus_2    (pc_plus_2),
    .ifid_wen     (ifid_wen),
    .ifid_flush   (ifid_flush),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: architectural PC, whether a miss is outstanding, and what to do when it returns.
  logic [15:0] m_pc;
  bit          m_halted;
  bit          m_miss;
  bit          m_halt_req;
  logic [15:0] m_redirect[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc       = 16'h0000;
    m_halted   = 1'b0;
    m_miss     = 1'b0;
    m_halt_req = 1'b0;
    m_redirect.delete();
  endtask

  task automatic check_outputs();
    logic e_wen, e_flush;
    e_wen   = 1'b0;
    e_flush = 1'b1;
    if (!m_halted && !m_miss) begin
      if (branch_taken || halt_decoded) e_flush = 1'b1;
      else if (hazard_stall) e_flush = 1'b0;
      else if (!imem_ready) e_flush = 1'b1;
      else begin
        e_flush = 1'b0;
        e_wen   = 1'b1;
      end
    end
    chk("pc_out", pc_out, m_pc);
    chk("pc_plus_2", pc_plus_2, m_pc + 16'd2);
    chk("imem_req", {15'd0, imem_req}, {15'd0, !m_halted});
    chk("ifid_wen", {15'd0, ifid_wen}, {15'd0, e_wen});
    chk("ifid_flush", {15'd0, ifid_flush}, {15'd0, e_flush});
    chk("halted", {15'd0, halted}, {15'd0, m_halted});
  endtask

  task automatic model_step();
    if (m_halted) return;
    if (m_miss) begin
      if (imem_ready) begin
        if (branch_taken) m_pc = branch_target;
        else if (m_redirect.size() > 0) m_pc = m_redirect[0];
        else if (m_halt_req) m_halted = 1'b1;
        m_miss     = 1'b0;
        m_halt_req = 1'b0;
        m_redirect.delete();
      end else if (branch_taken) begin
        m_redirect.delete();
        m_redirect.push_back(branch_target);
        m_halt_req = 1'b0;
      end else if (halt_decoded && m_redirect.size() == 0) begin
        m_halt_req = 1'b1;
      end
    end else if (branch_taken) m_pc = branch_target;
    else if (halt_decoded) m_halted = 1'b1;
    else if (hazard_stall) m_pc = m_pc;
    else if (!imem_ready) m_miss = 1'b1;
    else m_pc = m_pc + 16'd2;
  endtask

  // Drive one cycle of inputs, compare at the falling edge, advance the model at the rising edge.
  task automatic cycle(input bit br, input logic [15:0] tgt, input bit hz, input bit hl,
                       input bit rdy);
    branch_taken  = br;
    branch_target = tgt;
    hazard_stall  = hz;
    halt_decoded  = hl;
    imem_ready    = rdy;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc_out, 16'h0000);
    chk("async_rst_req", {15'd0, imem_req}, 16'h0000);
    chk("async_rst_halted", {15'd0, halted}, 16'h0000);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    hazard_stall  = 1'b0;
    halt_decoded  = 1'b0;
    imem_ready    = 1'b1;
    model_reset();
    #2;
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_req", {15'd0, imem_req}, 16'h0000);
    chk("rst_wen", {15'd0, ifid_wen}, 16'h0000);
    chk("rst_flush", {15'd0, ifid_flush}, 16'h0000);
    chk("rst_halted", {15'd0, halted}, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Sequential fetch.
    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", pc_out, 16'(2 * i));
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    end
    chk("seq_pc_end", pc_out, 16'h0008);

    // Three-cycle miss at 0008, then refetch and advance.
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("miss_hold", pc_out, 16'h0008);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("miss_refetch", pc_out, 16'h0008);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("miss_advance", pc_out, 16'h000A);

    // Hazard stall holds the PC.
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk("stall_hold", pc_out, 16'h000A);
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("pre_branch_pc", pc_out, 16'h0010);

    // Taken branch from 0010 to 0040.
    branch_taken  = 1'b1;
    branch_target = 16'h0040;
    #3;
    chk("br_flush", {15'd0, ifid_flush}, 16'h0001);
    chk("br_wen", {15'd0, ifid_wen}, 16'h0000);
    cycle(1'b1, 16'h0040, 1'b0, 1'b0, 1'b1);
    chk("br_target", pc_out, 16'h0040);

    // Branch and HLT together: branch wins.
    cycle(1'b1, 16'h0020, 1'b0, 1'b1, 1'b1);
    chk("br_over_halt_pc", pc_out, 16'h0020);
    chk("br_over_halt_h", {15'd0, halted}, 16'h0000);

    // Redirect during a miss is deferred until imem_ready; HLT after it is ignored.
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("pend_hold", pc_out, 16'h0020);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("pend_apply", pc_out, 16'h0100);

    // Wrap-around.
    cycle(1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    chk("wrap_pre", pc_out, 16'hFFFE);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("wrap_post", pc_out, 16'h0000);

    // HLT at 0030; branches afterwards are ignored.
    cycle(1'b1, 16'h0030, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    chk("halt_flag", {15'd0, halted}, 16'h0001);
    chk("halt_req", {15'd0, imem_req}, 16'h0000);
    for (int i = 0; i < 10; i++) cycle(i[0], 16'h0500, 1'b0, 1'b0, 1'b1);
    chk("halt_pc_frozen", pc_out, 16'h0030);

    // Reset out of HALTED, then HLT recorded during a miss.
    async_reset();
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("halt_pend_flag", {15'd0, halted}, 16'h0001);
    chk("halt_pend_pc", pc_out, 16'h0000);

    // Reset mid-miss with a redirect pending: pending state discarded.
    async_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("pre_miss_pc", pc_out, 16'h0006);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0200, 1'b0, 1'b0, 1'b0);
    async_reset();
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("post_rst_pc", pc_out, 16'h0002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
